// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state type and HI/LO-class decode for the multiply/divide unit.
// Honours MULDIV_DIV_EN: without it DIV/DIVU are not HI/LO-class and are ignored.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic is_hilo(input logic [5:0] code);
    case (code)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU: is_hilo = 1'b1;
`ifdef MULDIV_DIV_EN
      F_DIV, F_DIVU: is_hilo = 1'b1;
`endif
      default: is_hilo = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Radix-2 iteration engine: shift-add multiply and restoring divide on a 2*WIDTH pair.
// The divide path and its subtractor exist only when MULDIV_DIV_EN is defined.
module muldiv_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
`ifdef MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
`endif

  assign last = (count == CW'(WIDTH - 1));

  // Multiply: acc_lo holds the multiplier and shifts out as the product shifts in.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, operand};
    if (div_mode) begin
      if (trial[WIDTH]) begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        next_hi = trial[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      count   <= '0;
    end else if (load) begin
      acc_hi <= '0;
      count  <= '0;
`ifdef MULDIV_DIV_EN
      acc_lo  <= div_mode ? mag_a : mag_b;
      operand <= div_mode ? mag_b : mag_a;
`else
      acc_lo  <= mag_b;
      operand <= mag_a;
`endif
    end else if (step) begin
      acc_hi <= next_hi;
      acc_lo <= next_lo;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling and architectural HI/LO registers.
// Define MULDIV_DIV_EN to build DIV/DIVU support and the div_by_zero pulse.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] rd_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero
);

  state_t state, next_state;

  logic core_load, core_step, core_last, commit, write_hi, write_lo, div_zero;
  logic signed_op, sign_a, sign_b, neg_res;
  logic [WIDTH-1:0]   mag_a, mag_b, acc_hi, acc_lo;
  logic [2*WIDTH-1:0] product;
`ifdef MULDIV_DIV_EN
  logic is_div, div_op, neg_rem, core_div;

  assign is_div   = (funct == F_DIV) || (funct == F_DIVU);
  assign core_div = (state == IDLE) ? is_div : div_op;
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
`else
  assign signed_op = (funct == F_MULT);
  assign div_by_zero = 1'b0;
`endif

  assign sign_a  = signed_op & rs_val[WIDTH-1];
  assign sign_b  = signed_op & rt_val[WIDTH-1];
  assign mag_a   = sign_a ? -rs_val : rs_val;
  assign mag_b   = sign_b ? -rt_val : rt_val;
  assign product = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  assign busy   = (state != IDLE);
  assign stall  = start & busy & is_hilo(funct);
  assign rd_val = (funct == F_MFHI) ? hi : (funct == F_MFLO) ? lo : '0;

  muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
`ifdef MULDIV_DIV_EN
    .div_mode (core_div),
`endif
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .last   (core_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    commit     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    div_zero   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU: begin
              next_state = MUL;
              core_load  = 1'b1;
            end
`ifdef MULDIV_DIV_EN
            F_DIV, F_DIVU: begin
              if (rt_val == '0) begin
                div_zero = 1'b1;
              end else begin
                next_state = DIV;
                core_load  = 1'b1;
              end
            end
`endif
            F_MTHI:  write_hi = 1'b1;
            F_MTLO:  write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL: begin
        core_step = 1'b1;
        if (core_last) next_state = FIX;
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        core_step = 1'b1;
        if (core_last) next_state = FIX;
      end
`endif
      FIX: begin
        commit     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sign flags are latched with the operands; the core only ever sees magnitudes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_by_zero <= 1'b0;
      div_op      <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      done <= commit | div_zero;
`ifdef MULDIV_DIV_EN
      div_by_zero <= div_zero;
`endif
      if (core_load) begin
        neg_res <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
        neg_rem <= sign_a;
        div_op  <= is_div;
`endif
      end
      if (write_hi) hi <= rs_val;
      if (write_lo) lo <= rs_val;
      if (commit) begin
`ifdef MULDIV_DIV_EN
        if (div_op) begin
          lo <= neg_res ? -acc_lo : acc_lo;
          hi <= neg_rem ? -acc_hi : acc_hi;
        end else begin
          hi <= product[2*WIDTH-1:WIDTH];
          lo <= product[WIDTH-1:0];
        end
`else
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
`endif
      end
    end
  end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits beside the EX-stage ALU and takes over every HI/LO-class funct: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Multiply and divide run as multi-cycle radix-2 iterations. While an operation is in flight, the unit stalls any dependent HI/LO access from the pipeline.

## Interface
- WIDTH, 32, operand, HI and LO width (even, ≥4)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX-stage issue strobe, qualified by funct
- funct  in  6  MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- rs_val  in  WIDTH  multiplicand/dividend; MTHI/MTLO source
- rt_val  in  WIDTH  multiplier/divisor
- busy  out  1  high whenever state ≠ IDLE
- stall  out  1  combinational: start & busy & funct is any HI/LO-class code
- rd_val  out  WIDTH  combinational: hi when funct=MFHI, lo when funct=MFLO, else 0
- hi, lo  out  WIDTH  architectural registers
- done  out  1  one-cycle registered pulse on result commit
- div_by_zero  out  1  one-cycle registered pulse

## Operation
- FSM states:
  - IDLE
  - MUL: WIDTH iterations of shift-add on magnitudes, 2·WIDTH accumulator
  - DIV: WIDTH iterations of restoring shift-subtract on magnitudes
  - FIX: sign correction and commit
- IDLE transitions on start:
  - MULT/MULTU → MUL.
  - DIV/DIVU with rt_val≠0 → DIV.
  - DIV/DIVU with rt_val=0 → stay IDLE; pulse done and div_by_zero; hi/lo unchanged.
  - MTHI/MTLO → write hi/lo at that edge.
  - MFHI/MFLO → read only, no state change.
  - Unrecognised funct → ignored, no stall.
- MUL/DIV → FIX once the iteration counter reaches WIDTH-1. FIX → IDLE, with hi/lo written at that edge.
- Signed ops (MULT/DIV): operands are converted to magnitudes at start and the signs are captured.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Results: MUL sets hi = product[2W-1:W] and lo = product[W-1:0]. DIV sets lo = quotient and hi = remainder.
- DIV of most-negative by -1 produces lo = most-negative (wrap) and hi = 0. No flag is raised.
- Start while busy is ignored: stall=1 and the pipeline re-presents the request. Nothing is queued.
- Reset, including mid-operation: state=IDLE, hi=lo=0, done=div_by_zero=0, counter=0, and the in-flight result is discarded.

## Timing
- Start sampled in cycle N for MUL/DIV:
  - busy is high in cycles N+1 … N+WIDTH+1.
  - hi/lo hold the new values and done=1 in cycle N+WIDTH+2.
  - Latency is WIDTH+2 cycles.
- Div-by-zero: done=div_by_zero=1 in cycle N+1; busy stays 0.
- MTHI/MTLO: new value visible in cycle N+1.
- MFHI/MFLO: same-cycle combinational read when not busy. In cycle N+WIDTH+2 the read returns the new result.
- Back-to-back issue: a new start is accepted in cycle N+WIDTH+2. Throughput is one op per WIDTH+2 cycles.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU, the DIV state and div_by_zero are built.
- MULDIV_DIV_EN undefined:
  - DIV/DIVU are treated as unrecognised: ignored, no busy, no done.
  - div_by_zero is tied 0.
  - The DIV state and the subtractor are absent.

## Structure
- Package muldiv_pkg holds:
  - funct localparams for all eight codes
  - the state enum {IDLE, MUL, DIV, FIX}
  - a function classifying funct as HI/LO-class
- One sub-module, muldiv_shift_core, parametrised by WIDTH. It implements the per-iteration shift-add/shift-subtract step on the 2·WIDTH remainder/accumulator pair plus the iteration counter. The FSM, sign handling and HI/LO registers live in the top.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, start cycle N → hi=0xFFFFFFFE, lo=0x00000001, done exactly in N+34, busy N+1…N+33.
- MULT -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → done and div_by_zero in N+1, hi/lo unchanged, busy never high.
- MFLO presented continuously from N+5 during MULT → stall=1 through N+33, stall=0 in N+34 with rd_val = new lo; MTHI during busy likewise stalled and applied at N+34.
- DIVU 100/7 with rst in N+10 → N+11 shows busy=0, hi=lo=0, and no done pulse follows.
- Build without MULDIV_DIV_EN: DIV start → busy stays 0, no done, hi/lo unchanged; MULT still completes in WIDTH+2.
